fuzzy_channel_scheduler: RTL and testbench
==========================================

Name: fuzzy_channel_scheduler

Overview:
- Time-multiplexes one shared fuzzylogiccontroller instance across NCH sensor channels. Each channel has its own temperature/light pair.
- Round-robin over enabled channels: present the channel's T/L to the controller, wait a fixed settle time, capture pw into that channel's register.
- Drives one PWM output per channel from the captured pw values, updated glitch-free at PWM period boundaries.
- Sits between the sensor front-end and the actuator pins; the fuzzy controller is instantiated alongside it, not inside it.

Parameters:
- NCH, 4, number of channels (2..8).
- SETTLE_CYC, 16, cycles fz_t/fz_l are held before fz_pw is sampled (≥1; covers controller latency).
- DW, 8, data width of T, L and pw.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- t_in  in  NCH*DW  per-channel temperature; channel i at [i*DW +: DW].
- l_in  in  NCH*DW  per-channel light, same packing.
- ch_en  in  NCH  channel enable.
- fz_t  out  DW  T to the shared controller.
- fz_l  out  DW  L to the shared controller.
- fz_pw  in  DW  pw from the shared controller.
- pw_out  out  NCH*DW  captured pw per channel.
- upd_valid  out  1  one-cycle pulse when a channel's pw is captured.
- upd_ch  out  3  channel index for upd_valid.
- busy  out  1  high in LOAD/SETTLE/CAPTURE.
- pwm_out  out  NCH  per-channel PWM.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM in IDLE, last-served pointer = NCH-1, settle counter 0, PWM counter 0, all pw and shadow registers 0.
- FSM states:
  - IDLE: if any ch_en bit is set, pick the first enabled channel strictly after the last-served pointer (wrapping), then go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle): register that channel's t_in/l_in into fz_t/fz_l; load the settle counter with SETTLE_CYC-1; go to SETTLE.
  - SETTLE: count down to 0, then go to CAPTURE. fz_t/fz_l are held constant throughout; later changes on t_in/l_in are ignored.
  - CAPTURE (1 cycle): write fz_pw to pw_out[ch]; pulse upd_valid with upd_ch=ch; update the last-served pointer to ch; go to IDLE.
- Timing: one channel service takes SETTLE_CYC+3 cycles from IDLE. A full sweep of k enabled channels takes k*(SETTLE_CYC+3) cycles.
- Abort: if ch_en[ch] falls during LOAD or SETTLE, go to IDLE next cycle. No capture, no upd_valid, pointer unchanged. fz_t/fz_l hold their last values.
- ch_en changes while in IDLE take effect on the next selection. A single enabled channel is re-served back-to-back.
- A disabled channel keeps its last pw_out value; its pwm_out is forced to 0 immediately (combinational AND with ch_en).
- PWM generation:
  - 8-bit free-running counter, period 256 cycles.
  - pwm_out[i] = ch_en[i] && (cnt < shadow[i]).
  - shadow[i] loads pw_out[i] only on the cycle cnt==255, so a duty update never truncates or stretches a period.
  - Duty limits: pw=0 gives constant 0; pw=255 gives 255/256 high.
- Arithmetic: unsigned only. Comparison width is DW. The round-robin search wraps modulo NCH.
- Simultaneous events: a CAPTURE on the same cycle as cnt==255 loads the old value into shadow; the new value applies from the next period.

Decomposition:
- Package fuzzy_sched_pkg holds:
  - FSM state enum (IDLE, LOAD, SETTLE, CAPTURE);
  - DW default;
  - PWM counter width;
  - round-robin next-index helper function.
- One sub-module, fuzzy_pwm_gen: counter, shadow registers and comparators, parameterised by NCH/DW. The FSM and capture registers stay in the top module.

Test Plan:
- Bench uses a stub controller with fz_pw = (fz_t+fz_l)>>1 after 4 cycles; SETTLE_CYC=16.
- Single channel: ch_en=0001, T=110, L=130 → fz_t/fz_l=110/130 from the cycle after LOAD; upd_valid with upd_ch=0 exactly 19 cycles after leaving IDLE; pw_out[0]=120; after the next cnt==255, pwm_out[0] is high for 120 of every 256 cycles.
- Round-robin: ch_en=1111 with distinct T/L per channel → upd_ch sequence 0,1,2,3,0 at 19-cycle spacing. Then ch_en=1010 → sequence continues 1,3,1,3 with no service of channels 0 or 2.
- Abort: ch_en[2] cleared at cycle 5 of SETTLE → no upd_valid for channel 2, pw_out[2] unchanged, next service goes to channel 3.
- Extremes: T=240, L=240 (stub pw=240), then T=80, L=20 (pw=50) → duty changes 240/256 to 50/256 exactly at a period boundary, never a partial period. Forcing pw=0 gives constant low; pw=255 gives low only at cnt=255.
- Reset mid-SETTLE: rst_n pulsed low asynchronously → all outputs 0 immediately; after release, service restarts from channel 0.

Source files
------------

// File: rtl/fuzzy_sched_pkg.sv
// Shared types and helpers for the fuzzy channel scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fuzzy_sched_pkg;

  localparam int DW_DEF  = 8;   // default width of T, L and pw
  localparam int PWM_CW  = 8;   // PWM counter width, period 2**PWM_CW cycles
  localparam int MAX_NCH = 8;   // widest channel set the 3-bit index can address

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE
  } state_e;

  // First enabled channel strictly after 'last', wrapping modulo nch.
  // If only 'last' itself is enabled it is returned (back-to-back service).
  function automatic logic [2:0] rr_next(input logic [MAX_NCH-1:0] en,
                                         input logic [2:0]         last,
                                         input int                 nch);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_NCH; k++) begin
      idx = (int'(last) + k) % nch;
      if (!found && (k <= nch) && en[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fuzzy_pwm_gen.sv
// Per-channel PWM from captured pw values via shadow registers and a free-running counter.
// Latency: a new pw takes effect at the start of the next full PWM period; enable gating is combinational.
// Backpressure: none.
module fuzzy_pwm_gen
  import fuzzy_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = DW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NCH*DW-1:0] pw_i,
  input  logic [NCH-1:0]    en_i,
  output logic [NCH-1:0]    pwm_o
);

  logic [PWM_CW-1:0] cnt_q;
  logic [NCH*DW-1:0] shadow_q;
  logic [DW-1:0]     cnt_cmp;

  // Free-running period counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_q + 1'b1;
  end

  // Shadow copies only change on the last cycle of a period, so no period is cut short or stretched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        shadow_q <= '0;
    else if (cnt_q == {PWM_CW{1'b1}})   shadow_q <= pw_i;
  end

  assign cnt_cmp = DW'(cnt_q);

  // Compare per channel; a disabled channel is forced low at once.
  always_comb begin
    pwm_o = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_o[i] = en_i[i] && (cnt_cmp < shadow_q[i*DW +: DW]);
    end
  end

endmodule

// File: rtl/fuzzy_channel_scheduler.sv
// Round-robin time-multiplexing of one shared fuzzy controller across NCH sensor channels, plus per-channel PWM.
// Latency: SETTLE_CYC+3 cycles per channel service from IDLE; upd_valid/pw_out appear the cycle after CAPTURE.
// Backpressure: none; the controller output is sampled blindly after SETTLE_CYC cycles of stable inputs.
module fuzzy_channel_scheduler
  import fuzzy_sched_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int SETTLE_CYC = 16,
  parameter int DW         = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] t_in,
  input  logic [NCH*DW-1:0] l_in,
  input  logic [NCH-1:0]    ch_en,
  output logic [DW-1:0]     fz_t,
  output logic [DW-1:0]     fz_l,
  input  logic [DW-1:0]     fz_pw,
  output logic [NCH*DW-1:0] pw_out,
  output logic              upd_valid,
  output logic [2:0]        upd_ch,
  output logic              busy,
  output logic [NCH-1:0]    pwm_out
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e             state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [2:0]         last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      fz_t_q, fz_l_q;
  logic [NCH*DW-1:0]  pw_q;
  logic               upd_valid_q;
  logic [2:0]         upd_ch_q;
  logic [MAX_NCH-1:0] en_ext;
  logic               cur_en;
  logic [DW-1:0]      t_sel, l_sel;
  logic               load_go, cap_go;

  assign en_ext = MAX_NCH'(ch_en);
  assign cur_en = en_ext[ch_q];

  // Select the T/L pair of the channel being served.
  always_comb begin
    t_sel = '0;
    l_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == 3'(i)) begin
        t_sel = t_in[i*DW +: DW];
        l_sel = l_in[i*DW +: DW];
      end
    end
  end

  // FSM state register with channel, last-served pointer and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      last_q  <= 3'(NCH - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: pick, load, settle, capture; dropping the served channel's enable aborts without capture.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|ch_en) begin
          ch_d    = rr_next(en_ext, last_q, NCH);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!cur_en) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CW'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!cur_en)           state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_CAPTURE;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      ST_CAPTURE: begin
        last_d  = ch_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the load/capture strobes for the datapath.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    load_go = (state_q == ST_LOAD) && cur_en;
    cap_go  = (state_q == ST_CAPTURE);
  end

  // Controller inputs are latched once at LOAD and held until the next LOAD; pw is captured per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fz_t_q      <= '0;
      fz_l_q      <= '0;
      pw_q        <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      upd_valid_q <= cap_go;
      if (load_go) begin
        fz_t_q <= t_sel;
        fz_l_q <= l_sel;
      end
      if (cap_go) upd_ch_q <= ch_q;
      for (int i = 0; i < NCH; i++) begin
        if (cap_go && (ch_q == 3'(i))) pw_q[i*DW +: DW] <= fz_pw;
      end
    end
  end

  assign fz_t      = fz_t_q;
  assign fz_l      = fz_l_q;
  assign pw_out    = pw_q;
  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;

  fuzzy_pwm_gen #(
    .NCH (NCH),
    .DW  (DW)
  ) u_pwm (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pw_i   (pw_q),
    .en_i   (ch_en),
    .pwm_o  (pwm_out)
  );

endmodule

// File: tb/tb_fuzzy_channel_scheduler.sv
module tb_fuzzy_channel_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int SC  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] t_in, l_in;
  logic [NCH-1:0]    ch_en;
  logic [DW-1:0]     fz_t, fz_l, fz_pw;
  logic [NCH*DW-1:0] pw_out;
  logic              upd_valid;
  logic [2:0]        upd_ch;
  logic              busy;
  logic [NCH-1:0]    pwm_out;

  always #5 clk = ~clk;

  fuzzy_channel_scheduler #(.NCH(NCH), .SETTLE_CYC(SC), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .l_in(l_in), .ch_en(ch_en),
    .fz_t(fz_t), .fz_l(fz_l), .fz_pw(fz_pw), .pw_out(pw_out),
    .upd_valid(upd_valid), .upd_ch(upd_ch), .busy(busy), .pwm_out(pwm_out)
  );

  // Stub controller: pw = (T+L)>>1, four cycles of latency.
  logic [8:0]    stub_sum;
  logic [DW-1:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  assign stub_sum = {1'b0, fz_t} + {1'b0, fz_l};
  always @(posedge clk) begin
    s0 <= stub_sum[8:1];
    s1 <= s0;
    s2 <= s1;
    s3 <= s2;
  end
  assign fz_pw = s3;

  // Bench view of the free-running PWM period position.
  logic [7:0] mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= '0;
    else        mcnt <= mcnt + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int pw;
    int gap;
    bit from_start;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   start_cyc = 0;
  int   last_evt  = 0;
  int   ref_cyc;

  bit   feed_on = 1'b0;
  bit   first_push = 1'b0;
  int   nxt_t, nxt_l, nxt_pw;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every update pulse is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && upd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_upd_ch", int'(upd_ch), -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_ch", int'(upd_ch), mon_e.ch);
        check("pw_out_on_upd", int'(pw_out[mon_e.ch*DW +: DW]), mon_e.pw);
        ref_cyc = mon_e.from_start ? start_cyc : last_evt;
        if (mon_e.gap > 0) check("upd_spacing", cyc - ref_cyc, mon_e.gap);
      end
      last_evt = cyc;
    end
  end

  task automatic set_tl(input int ch, input int t, input int l);
    logic [7:0] tv, lv;
    tv = t[7:0];
    lv = l[7:0];
    t_in[ch*DW +: DW] = tv;
    l_in[ch*DW +: DW] = lv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input int ch, input int pw, input int gap, input bit fs);
    exp_t e;
    e.ch = ch; e.pw = pw; e.gap = gap; e.from_start = fs;
    exp_q.push_back(e);
  endtask

  // Keeps channel 0 supplied: in each LOAD cycle drive the next T/L and expect its hand-computed pw.
  task automatic feed_loop();
    while (feed_on) begin
      @(posedge clk);
      #1;
      if (feed_on && exp_q.size() == 0) begin
        set_tl(0, nxt_t, nxt_l);
        push(0, nxt_pw, 19, first_push);
        first_push = 1'b0;
      end
    end
  endtask

  task automatic wait_size(input int n);
    int g;
    g = 0;
    @(posedge clk);
    #1;
    while (exp_q.size() > n && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 400) check("wait_queue_timeout", exp_q.size(), n);
  endtask

  // Let pending services finish, then drop all enables (lands in LOAD/SETTLE, so no extra capture).
  task automatic stop_service();
    wait_size(0);
    ch_en = '0;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_stop", int'(busy), 0);
  endtask

  // One aligned PWM period on channel 0: high count and exact shape (high exactly for cnt < duty).
  task automatic check_period(input int duty, input string tag);
    int g, highs, badpos;
    bit expb;
    g = 0;
    @(negedge clk);
    while (mcnt != 8'd0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (g >= 600) check({tag, "_align_timeout"}, g, 0);
    highs  = 0;
    badpos = 0;
    for (int k = 0; k < 256; k++) begin
      expb = (k < duty);
      if (pwm_out[0]) highs++;
      if (pwm_out[0] != expb) badpos++;
      @(negedge clk);
    end
    check({tag, "_duty"}, highs, duty);
    check({tag, "_shape_errs"}, badpos, 0);
  endtask

  initial begin
    int g;
    t_in  = '0;
    l_in  = '0;
    ch_en = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fz_t", int'(fz_t), 0);
    check("rst_fz_l", int'(fz_l), 0);
    check("rst_pw_out", int'(pw_out != '0), 0);
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_upd_ch", int'(upd_ch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_enable_busy", int'(busy), 0);

    // Single channel, then duty extremes on the same channel with back-to-back service.
    nxt_t = 110; nxt_l = 130; nxt_pw = 120;
    first_push = 1'b1;
    feed_on    = 1'b1;
    start_cyc  = cyc;
    ch_en      = 4'b0001;
    fork
      feed_loop();
      begin
        @(negedge clk);
        check("fz_t_during_load", int'(fz_t), 0);
        @(negedge clk);
        check("fz_t_after_load", int'(fz_t), 110);
        check("fz_l_after_load", int'(fz_l), 130);
        check("busy_in_settle", int'(busy), 1);
        repeat (45) @(negedge clk);
        check_period(120, "pwm120");
        nxt_t = 240; nxt_l = 240; nxt_pw = 240;
        repeat (45) @(negedge clk);
        check_period(240, "pwm240");
        nxt_t = 80; nxt_l = 20; nxt_pw = 50;
        repeat (45) @(negedge clk);
        check_period(50, "pwm50");
        nxt_t = 255; nxt_l = 255; nxt_pw = 255;
        repeat (45) @(negedge clk);
        check_period(255, "pwm255");
        nxt_t = 0; nxt_l = 0; nxt_pw = 0;
        repeat (45) @(negedge clk);
        check_period(0, "pwm0");
        nxt_t = 110; nxt_l = 130; nxt_pw = 120;
        repeat (45) @(negedge clk);
        check_period(120, "pwm120b");
        feed_on = 1'b0;
      end
    join
    stop_service();
    g = 0;
    while (mcnt != 8'd10 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("disabled_pwm_forced_low", int'(pwm_out[0]), 0);
    check("disabled_keeps_pw", int'(pw_out[7:0]), 120);

    // Round-robin over all four channels, then over channels 1 and 3 only.
    do_reset();
    set_tl(0, 10, 20);
    set_tl(1, 50, 70);
    set_tl(2, 100, 120);
    set_tl(3, 200, 250);
    @(negedge clk);
    push(0, 15, 19, 1'b1);
    push(1, 60, 19, 1'b0);
    push(2, 110, 19, 1'b0);
    push(3, 225, 19, 1'b0);
    push(0, 15, 19, 1'b0);
    push(1, 60, 19, 1'b0);
    push(3, 225, 19, 1'b0);
    push(1, 60, 19, 1'b0);
    push(3, 225, 19, 1'b0);
    start_cyc = cyc;
    ch_en = 4'b1111;
    wait_size(4);
    ch_en = 4'b1010;
    stop_service();

    // Abort: channel 2 disabled in the fifth SETTLE cycle.
    do_reset();
    @(negedge clk);
    push(0, 15, 19, 1'b1);
    push(1, 60, 19, 1'b0);
    push(3, 225, 26, 1'b0);
    push(0, 15, 19, 1'b0);
    start_cyc = cyc;
    ch_en = 4'b1111;
    wait_size(2);
    repeat (6) @(negedge clk);
    ch_en = 4'b1011;
    @(negedge clk);
    check("abort_busy_low", int'(busy), 0);
    check("abort_fz_t_held", int'(fz_t), 100);
    check("abort_fz_l_held", int'(fz_l), 120);
    stop_service();
    check("abort_pw2_unchanged", int'(pw_out[2*DW +: DW]), 0);

    // Asynchronous reset in the middle of SETTLE, then service restarts at channel 0.
    do_reset();
    @(negedge clk);
    push(0, 15, 19, 1'b1);
    push(1, 60, 19, 1'b0);
    start_cyc = cyc;
    ch_en = 4'b1111;
    wait_size(0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_fz_t", int'(fz_t), 0);
    check("midrst_pw_out", int'(pw_out != '0), 0);
    check("midrst_upd_ch", int'(upd_ch), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pwm_out", int'(pwm_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_cyc = cyc;
    push(0, 15, 19, 1'b1);
    stop_service();

    repeat (5) @(negedge clk);
    check("leftover_expectations", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
